sync_fifo_level: RTL and testbench
==================================

# sync_fifo_level

Parametrised synchronous FIFO with an occupancy counter, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. This is the general-purpose single-clock buffer for the datapath. It generalises the fixed 8-bit × 512 counter FIFO:
- any width and power-of-two depth;
- a count that represents completely full;
- an optional first-word-fall-through read mode.

## Interface
- `DATA_WIDTH`, 8, width of a stored word
- `ADDR_WIDTH`, 9, storage address width; `DEPTH = 2**ADDR_WIDTH` entries
- `AF_LEVEL`, `DEPTH-4`, `almost_full` asserts when `fcounter >= AF_LEVEL`
- `AE_LEVEL`, 4, `almost_empty` asserts when `fcounter <= AE_LEVEL`
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `w_enable`  in  1  write request
- `w_data`  in  `DATA_WIDTH`  write word
- `r_enable`  in  1  read request
- `clr_err`  in  1  synchronous clear of `overflow`/`underflow`
- `r_data`  out  `DATA_WIDTH`  read word
- `r_valid`  out  1  `r_data` holds a freshly popped word (standard mode)
- `full`  out  1  `fcounter == DEPTH`
- `empty`  out  1  no word readable
- `almost_full`  out  1  threshold flag
- `almost_empty`  out  1  threshold flag
- `fcounter`  out  `ADDR_WIDTH+1`  occupancy, 0..`DEPTH`
- `overflow`  out  1  sticky: a write was rejected
- `underflow`  out  1  sticky: a read was rejected

## Operation
- **Accept rules:** `w_allow = w_enable & !full`; `r_allow = r_enable & !empty`. Both are evaluated on pre-edge flags. When full, a simultaneous read and write accepts only the read; the write is dropped and `overflow` sets.
- **Pointers:** `w_addr` and `r_addr` are `ADDR_WIDTH` bits wide. Each increments on its allow and wraps modulo `DEPTH`.
- **Counter update:**
  - `fcounter` += 1 on write-only.
  - `fcounter` −= 1 on read-only.
  - Unchanged when both or neither are allowed.
  - It never exceeds `DEPTH` and never goes below 0.
- **Registered flags:** all flags are registered and computed from the next-state count, so they agree with `fcounter` on every cycle.
- **Errors:**
  - `overflow` sets on `w_enable & full`.
  - `underflow` sets on `r_enable & empty`.
  - Both hold until `clr_err` or `reset`. If `clr_err` and a new error occur in the same cycle, the error wins (the flag stays 1).
- **Threshold guard:** if `AF_LEVEL > DEPTH` or `AE_LEVEL >= DEPTH`, the block raises an elaboration-time error.

## Timing
- **Reset values:**
  - `empty` = 1, `almost_empty` = 1.
  - `full` = 0, `almost_full` = 0.
  - `fcounter` = 0, both pointers = 0.
  - `overflow` = `underflow` = 0.
  - `r_valid` = 0, `r_data` = 0.
- **Reset mid-operation:** all state clears immediately and contents are discarded. RAM contents are not cleared.
- **Write to flags:** a write accepted at edge N updates `fcounter`, `empty` and `full` on the outputs just after edge N.
- **Standard read latency:** a read accepted at edge N presents the word on `r_data` with `r_valid = 1` after edge N+1. `r_valid` is a single-cycle pulse per read. `r_data` holds its value between reads.
- **Back-to-back:** one word in and one word out per cycle sustained, with no bubbles.
- **Write then read same address:** a word written at edge N is readable by a read accepted at edge N+1. The RAM has no read-during-write hazard path.

## Configuration
- **Macro `SYNC_FIFO_FWFT_EN` defined (first-word fall-through):**
  - The head word is preloaded into an output register, so `r_data` is valid whenever `empty = 0`.
  - `r_enable` pops the word.
  - `r_valid` is tied to `!empty`.
  - `fcounter` includes the output-register word.
  - First write into an empty FIFO at edge N: `empty` deasserts after edge N+1.
  - The next word appears on `r_data` the cycle after a pop.
- **Macro not defined:** standard one-cycle read latency as described under Timing.

## Structure
- **Package `sync_fifo_pkg`:**
  - Localparam helpers for `DEPTH` and count width (`ADDR_WIDTH+1`).
  - Default threshold constants.
  - The threshold-legality check function.
- **Sub-module `sync_fifo_ram`:**
  - Simple dual-port RAM, `DATA_WIDTH` × `DEPTH`.
  - One write port and one registered read port, both on `clk`.
  - No reset on the storage array.
- **Top level:** pointers, counter, flags, error logic and the FWFT output stage.

## Test plan
All scenarios use `DATA_WIDTH=8`, `ADDR_WIDTH=4` (`DEPTH` 16), `AF_LEVEL=14`, `AE_LEVEL=2`.
- **Reset then one write:** write 0xA5 → next cycle `fcounter=1`, `empty=0`. Read → `r_data=0xA5` with `r_valid=1` one cycle after accept, `empty=1`.
- **Fill to full:** write 0x00..0x0F back-to-back → `almost_full` rises at count 14, `full=1` at count 16. A 17th write sets `overflow` and leaves `fcounter=16`. Drain returns 0x00..0x0F in order.
- **Simultaneous read/write:**
  - At count 8: `fcounter` stays 8 and data order is preserved.
  - At count 16: only the read is accepted, count becomes 15, and `overflow` sets.
- **Underflow and clear:** read while empty → `underflow=1`, pointers unchanged. Pulse `clr_err` → 0. `clr_err` together with a new empty read → stays 1.
- **Wrap-around:** 40 words streamed with reads lagging by 3 → all 40 words read back in order, and `fcounter` never exceeds 4.
- **Reset mid-stream:** assert `reset` at count 9 → all outputs take their reset values asynchronously. A subsequent write/read of 0x3C returns 0x3C.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing helpers, default thresholds and threshold legality check
package sync_fifo_pkg;

    localparam int AE_LEVEL_DEF  = 4;
    localparam int AF_MARGIN_DEF = 4;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit thresholds_ok(input int depth, input int af_level, input int ae_level);
        return (af_level >= 0) && (af_level <= depth) && (ae_level >= 0) && (ae_level < depth);
    endfunction

endpackage

// File: rtl/sync_fifo_level_if.sv
// rtl/sync_fifo_level_if.sv - write/read/status bundle of the level-tracking FIFO
interface sync_fifo_level_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
);
    logic                              w_enable;
    logic [DATA_WIDTH-1:0]             w_data;
    logic                              r_enable;
    logic                              clr_err;
    logic [DATA_WIDTH-1:0]             r_data;
    logic                              r_valid;
    logic                              full;
    logic                              empty;
    logic                              almost_full;
    logic                              almost_empty;
    logic [count_width(ADDR_WIDTH)-1:0] fcounter;
    logic                              overflow;
    logic                              underflow;

    modport master (
        output w_enable, w_data, r_enable, clr_err,
        input  r_data, r_valid, full, empty, almost_full, almost_empty,
               fcounter, overflow, underflow
    );

    modport slave (
        input  w_enable, w_data, r_enable, clr_err,
        output r_data, r_valid, full, empty, almost_full, almost_empty,
               fcounter, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - simple dual-port storage, one write port and one registered read port
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/sync_fifo_level.sv
// rtl/sync_fifo_level.sv - single-clock FIFO with occupancy count, threshold and sticky error flags
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_level
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - AF_MARGIN_DEF,
    parameter int AE_LEVEL   = AE_LEVEL_DEF
) (
    input logic              clk,
    input logic              reset,
    sync_fifo_level_if.slave bus
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int CW    = count_width(ADDR_WIDTH);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t AF_C    = cnt_t'(AF_LEVEL);
    localparam cnt_t AE_C    = cnt_t'(AE_LEVEL);

    if (!thresholds_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_threshold
        $error("sync_fifo_level: AF_LEVEL must be <= DEPTH and AE_LEVEL < DEPTH");
    end

    logic [ADDR_WIDTH-1:0] w_addr, r_addr;
    cnt_t                  cnt_q, cnt_d;
    logic                  w_allow, r_allow, ram_re;
    logic [DATA_WIDTH-1:0] ram_q;

    always_comb begin
        w_allow = bus.w_enable & ~bus.full;
        r_allow = bus.r_enable & ~bus.empty;
        cnt_d   = cnt_q;
        if (w_allow & ~r_allow) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else if (r_allow & ~w_allow) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
    end

    // Flags come from the next count so they always agree with fcounter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_addr           <= '0;
            r_addr           <= '0;
            cnt_q            <= '0;
            bus.full         <= 1'b0;
            bus.almost_full  <= 1'b0;
            bus.almost_empty <= 1'b1;
            bus.overflow     <= 1'b0;
            bus.underflow    <= 1'b0;
        end else begin
            if (w_allow) begin
                w_addr <= w_addr + ADDR_WIDTH'(1);
            end
            if (ram_re) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            cnt_q            <= cnt_d;
            bus.full         <= (cnt_d == DEPTH_C);
            bus.almost_full  <= (cnt_d >= AF_C);
            bus.almost_empty <= (cnt_d <= AE_C);
            bus.overflow     <= (bus.w_enable & bus.full)  | (bus.overflow  & ~bus.clr_err);
            bus.underflow    <= (bus.r_enable & bus.empty) | (bus.underflow & ~bus.clr_err);
        end
    end

    assign bus.fcounter = cnt_q;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_allow),
        .waddr (w_addr),
        .wdata (bus.w_data),
        .re    (ram_re),
        .raddr (r_addr),
        .rdata (ram_q)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // The RAM read register doubles as the head-word register; r_addr points at the next word to fetch.
    logic out_valid;
    logic fetch;
    cnt_t ram_words;

    always_comb begin
        ram_words = cnt_q - cnt_t'(out_valid);
        fetch     = (ram_words != '0) & (~out_valid | r_allow);
    end

    assign ram_re = fetch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (fetch) begin
            out_valid <= 1'b1;
        end else if (r_allow) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.empty   = ~out_valid;
    assign bus.r_valid = out_valid;
    assign bus.r_data  = out_valid ? ram_q : '0;
`else
    logic rd_pend;

    assign ram_re = r_allow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend     <= 1'b0;
            bus.r_valid <= 1'b0;
            bus.r_data  <= '0;
            bus.empty   <= 1'b1;
        end else begin
            rd_pend     <= r_allow;
            bus.r_valid <= rd_pend;
            if (rd_pend) begin
                bus.r_data <= ram_q;
            end
            bus.empty <= (cnt_d == '0);
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_level.sv
// tb/tb_sync_fifo_level.sv - self-checking bench for sync_fifo_level (DEPTH 16, AF 14, AE 2)
module tb_sync_fifo_level;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sync_fifo_level_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    sync_fifo_level #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .AF_LEVEL   (14),
        .AE_LEVEL   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: queue of stored words plus a one-deep slot for the word in flight to r_data.
    bit [7:0] q[$];
    bit       m_ovf, m_unf, m_pend, m_rv;
    bit [7:0] m_pend_d, m_rd;

    typedef struct {
        bit       we;
        bit [7:0] wd;
        bit       re;
        bit       clr;
        int       cnt;
        bit       empty, full, af, ae, ovf, unf, rv;
        bit [7:0] rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_status();
        return 32'({bus.fcounter, bus.empty, bus.full, bus.almost_full, bus.almost_empty,
                    bus.overflow, bus.underflow, bus.r_valid, bus.r_data});
    endfunction

    function automatic logic [31:0] pack_status(input int cnt, input bit e, input bit f, input bit af,
                                                 input bit ae, input bit ov, input bit un,
                                                 input bit rv, input bit [7:0] rd);
        return 32'({5'(cnt), e, f, af, ae, ov, un, rv, rd});
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_unf = 0; m_pend = 0; m_rv = 0; m_pend_d = 0; m_rd = 0;
    endtask

    task automatic model_step(input bit we, input bit [7:0] wd, input bit re, input bit clr);
        bit is_full, is_empty, wa, ra;
        is_full  = (q.size() == 16);
        is_empty = (q.size() == 0);
        wa = we && !is_full;
        ra = re && !is_empty;
        m_rv = m_pend;
        if (m_pend) m_rd = m_pend_d;
        m_pend = ra;
        if (ra) m_pend_d = q.pop_front();
        if (wa) q.push_back(wd);
        m_ovf = (we && is_full)  || (m_ovf && !clr);
        m_unf = (re && is_empty) || (m_unf && !clr);
    endtask

    task automatic check_model(input string name);
        int n;
        n = q.size();
        check(name, dut_status(),
              pack_status(n, n == 0, n == 16, n >= 14, n <= 2, m_ovf, m_unf, m_rv, m_rd));
    endtask

    task automatic cycle(input bit we, input bit [7:0] wd, input bit re, input bit clr);
        bus.w_enable = we;
        bus.w_data   = wd;
        bus.r_enable = re;
        bus.clr_err  = clr;
        model_step(we, wd, re, clr);
        @(posedge clk);
        #1;
        bus.w_enable = 1'b0;
        bus.r_enable = 1'b0;
        bus.clr_err  = 1'b0;
    endtask

    task automatic add(input bit we, input bit [7:0] wd, input bit re, input bit clr, input int cnt,
                       input bit e, input bit f, input bit af, input bit ae, input bit ov,
                       input bit un, input bit rv, input bit [7:0] rd);
        vec_t v;
        v.we = we; v.wd = wd; v.re = re; v.clr = clr; v.cnt = cnt;
        v.empty = e; v.full = f; v.af = af; v.ae = ae; v.ovf = ov; v.unf = un; v.rv = rv; v.rd = rd;
        vecs.push_back(v);
    endtask

    initial begin
        int max_cnt;
        int n_rv;

        //   we wd     re clr cnt e  f  af ae ov un rv rd
        add(1, 8'hA5, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0, 8'h00);
        add(0, 8'h00, 1, 0,  0, 1, 0, 0, 1, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0,  0, 1, 0, 0, 1, 0, 0, 1, 8'hA5);
        add(0, 8'h00, 0, 0,  0, 1, 0, 0, 1, 0, 0, 0, 8'hA5);
        add(0, 8'h00, 1, 0,  0, 1, 0, 0, 1, 0, 1, 0, 8'hA5);
        add(0, 8'h00, 0, 1,  0, 1, 0, 0, 1, 0, 0, 0, 8'hA5);
        add(0, 8'h00, 1, 1,  0, 1, 0, 0, 1, 0, 1, 0, 8'hA5);
        add(0, 8'h00, 0, 1,  0, 1, 0, 0, 1, 0, 0, 0, 8'hA5);
        add(1, 8'h3C, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0, 8'hA5);
        add(1, 8'hC3, 1, 0,  1, 0, 0, 0, 1, 0, 0, 0, 8'hA5);
        add(0, 8'h00, 1, 0,  0, 1, 0, 0, 1, 0, 0, 1, 8'h3C);
        add(0, 8'h00, 0, 0,  0, 1, 0, 0, 1, 0, 0, 1, 8'hC3);
        add(0, 8'h00, 0, 0,  0, 1, 0, 0, 1, 0, 0, 0, 8'hC3);

        reset = 1'b1;
        bus.w_enable = 1'b0; bus.w_data = '0; bus.r_enable = 1'b0; bus.clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_status(), pack_status(0, 1, 0, 0, 1, 0, 0, 0, 8'h00));
        reset = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].clr);
            check($sformatf("vec%0d", i), dut_status(),
                  pack_status(vecs[i].cnt, vecs[i].empty, vecs[i].full, vecs[i].af, vecs[i].ae,
                              vecs[i].ovf, vecs[i].unf, vecs[i].rv, vecs[i].rd));
        end

        // Fill to full, overflow, clear, then read+write while full.
        for (int i = 0; i < 16; i++) begin
            cycle(1, 8'(i), 0, 0);
            check_model($sformatf("fill%0d", i));
        end
        cycle(1, 8'hEE, 0, 0);
        check_model("write_when_full");
        cycle(0, 8'h00, 0, 1);
        check_model("clr_ovf");
        cycle(1, 8'hEE, 1, 0);
        check_model("rw_when_full");
        for (int i = 0; i < 17; i++) begin
            cycle(0, 8'h00, 1, 0);
            check_model($sformatf("drain%0d", i));
        end

        // Simultaneous read/write at count 8.
        for (int i = 0; i < 8; i++) cycle(1, 8'(8'h80 + i), 0, 0);
        check_model("cnt8");
        for (int i = 0; i < 6; i++) begin
            cycle(1, 8'(8'h90 + i), 1, 0);
            check_model($sformatf("rw8_%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            cycle(0, 8'h00, 1, 0);
            check_model($sformatf("drain8_%0d", i));
        end
        cycle(0, 8'h00, 0, 1);
        check_model("clr_after_drain8");

        // Wrap-around stream with reads lagging three cycles.
        max_cnt = 0;
        n_rv = 0;
        for (int i = 0; i < 45; i++) begin
            cycle(i < 40, 8'(8'h40 + i), (i >= 3) && (i < 43), 0);
            check_model($sformatf("wrap%0d", i));
            if (int'(bus.fcounter) > max_cnt) max_cnt = int'(bus.fcounter);
            if (bus.r_valid) n_rv++;
        end
        check("wrap_max_count_le4", 32'(max_cnt <= 4), 32'(1));
        check("wrap_words_read", 32'(n_rv), 32'(40));

        // Reset in the middle of a stream at count 9.
        for (int i = 0; i < 10; i++) cycle(1, 8'(8'h50 + i), 0, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);
        check_model("pre_reset_cnt9");
        reset = 1'b1;
        #2;
        check("async_reset_state", dut_status(), pack_status(0, 1, 0, 0, 1, 0, 0, 0, 8'h00));
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1, 8'h3C, 0, 0);
        check_model("post_reset_write");
        cycle(0, 8'h00, 1, 0);
        check_model("post_reset_read");
        cycle(0, 8'h00, 0, 0);
        check("post_reset_data", 32'({bus.r_valid, bus.r_data}), 32'({1'b1, 8'h3C}));

        // Randomized traffic: write-heavy then read-heavy phases to visit both boundaries.
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = (i % 100) < 50 ? 75 : 25;
            cycle($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < (100 - wp),
                  $urandom_range(0, 99) < 5);
            check_model($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
